// File: rtl/cpu7_ifu_ibuf.sv
// cpu7 IFU instruction buffer: takes 1-4 instruction fetch groups and issues one instruction per cycle to decode.
// Optional same-cycle bypass of an empty buffer is enabled by defining CPU7_IBUF_BYPASS_EN.
module cpu7_ifu_ibuf #(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         fdp_ibuf_valid,
  input  logic [31:0]  fdp_ibuf_pc,
  input  logic [127:0] fdp_ibuf_rdata,
  input  logic [1:0]   fdp_ibuf_count,
  input  logic         fdp_ibuf_ex,
  input  logic [5:0]   fdp_ibuf_exccode,
  output logic         ibuf_fdp_ready,
  input  logic         flush,
  input  logic         exu_ifu_stall_req,
  output logic         ibuf_dec_valid,
  output logic [31:0]  ibuf_dec_pc,
  output logic [31:0]  ibuf_dec_inst,
  output logic         ibuf_dec_ex,
  output logic [5:0]   ibuf_dec_exccode
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 4);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  exccode;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   occ_q, occ_d;

  entry_t        grp [4];
  entry_t        out_ent;
  logic          empty;
  logic          push;
  logic          pop;
  logic          byp;
  logic          byp_take;
  logic [2:0]    push_n;
  logic [2:0]    wr_cnt;
  logic [1:0]    wr_ofs;
  logic [2:0]    push_amt;

  assign empty          = (occ_q == '0);
  assign ibuf_fdp_ready = (occ_q <= READY_MAX);
  assign push           = fdp_ibuf_valid & ibuf_fdp_ready & ~flush;
  // An exception group always collapses to a single entry.
  assign push_n         = fdp_ibuf_ex ? 3'd1 : {1'b0, fdp_ibuf_count} + 3'd1;

`ifdef CPU7_IBUF_BYPASS_EN
  assign byp      = push & empty;
  assign byp_take = byp & ~exu_ifu_stall_req;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A bypassed-and-consumed word 0 is never stored, so writing starts at word 1.
  assign wr_cnt   = byp_take ? push_n - 3'd1 : push_n;
  assign wr_ofs   = byp_take ? 2'd1 : 2'd0;
  assign push_amt = push ? wr_cnt : 3'd0;
  assign pop      = ~empty & ~flush & ~exu_ifu_stall_req;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      grp[k].pc      = fdp_ibuf_pc + 32'(4 * k);
      grp[k].inst    = fdp_ibuf_ex ? 32'h0 : fdp_ibuf_rdata[32*k +: 32];
      grp[k].ex      = fdp_ibuf_ex;
      grp[k].exccode = fdp_ibuf_ex ? fdp_ibuf_exccode : 6'h0;
    end
  end

  always_comb begin
    if (byp)        out_ent = grp[0];
    else if (empty) out_ent = '0;
    else            out_ent = mem_q[head_q];
  end

  assign ibuf_dec_valid   = (~empty | byp) & ~flush;
  assign ibuf_dec_pc      = out_ent.pc;
  assign ibuf_dec_inst    = out_ent.inst;
  assign ibuf_dec_ex      = out_ent.ex;
  assign ibuf_dec_exccode = out_ent.exccode;

  always_comb begin
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      head_d = head_q + AW'(pop);
      tail_d = tail_q + AW'(push_amt);
      occ_d  = occ_q + (AW+1)'(push_amt) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // NOTE: storage has no reset; empty is judged from occ_q alone, so stale contents are never visible.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (push && (3'(k) < wr_cnt)) begin
        mem_q[tail_q + AW'(k)] <= grp[2'(k) + wr_ofs];
      end
    end
  end

endmodule

// File: doc/cpu7_ifu_ibuf.md
# cpu7_ifu_ibuf

Instruction fetch buffer between the fetch datapath and the decoder in the cpu7 IFU. Accepts fetch groups of 1–4 instructions from the 128-bit fetch return and issues them one per cycle, in program order, to decode. Handles flush on a taken branch and holds issue on an EXU stall. This decouples fetch-return bursts from single-issue decode.

## Interface
Parameters:
- DEPTH, 8: entry count; power of two, ≥4.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fdp_ibuf_valid  in  1  fetch group present this cycle.
- fdp_ibuf_pc  in  32  PC of instruction word 0 of the group.
- fdp_ibuf_rdata  in  128  word i (bits 32i+31:32i) is the instruction at pc+4i.
- fdp_ibuf_count  in  2  number of valid words minus 1 (0→1 word, 3→4 words).
- fdp_ibuf_ex  in  1  fetch exception for this group.
- fdp_ibuf_exccode  in  6  exception code, meaningful when ex=1.
- ibuf_fdp_ready  out  1  buffer can take a full 4-instruction group.
- flush  in  1  taken-branch flush (driven from exu_ifu_br_taken).
- exu_ifu_stall_req  in  1  decode/execute cannot accept this cycle.
- ibuf_dec_valid  out  1  head entry presented to decode.
- ibuf_dec_pc  out  32  head PC.
- ibuf_dec_inst  out  32  head instruction.
- ibuf_dec_ex  out  1  head carries fetch exception.
- ibuf_dec_exccode  out  6  head exception code.

## Operation
- Circular buffer of DEPTH entries {pc, inst, ex, exccode}, with a head pointer, a tail pointer (log2 DEPTH bits, wrap modulo DEPTH) and an occupancy counter (log2 DEPTH + 1 bits).
- Push: fdp_ibuf_valid & ibuf_fdp_ready & ~flush.
  - ex=0: write count+1 entries at tail..tail+count (wrapping); entry k gets pc+4k and word k. Tail advances by count+1.
  - ex=1: write exactly one entry {pc, inst=32'h0, ex=1, exccode}; count and rdata are ignored. Tail advances by 1.
- Push with ready=0 is dropped. Fetch must hold or replay the group; the buffer does not store it.
- ibuf_fdp_ready = (DEPTH − occupancy) ≥ 4. It is computed from current occupancy only, with no pop credit.
- Pop: ibuf_dec_valid & ~exu_ifu_stall_req. Head advances by 1.
- Simultaneous push and pop: occupancy += pushed − 1.
- Outputs present the head entry. ibuf_dec_valid = (occupancy≠0) & ~flush.
- Flush: head, tail and occupancy all go to 0 at the edge. A push or pop in the flush cycle is discarded. Flush has priority over push, pop and stall.
- Reset: same as flush. After reset: ibuf_dec_valid=0, ibuf_fdp_ready=1, pc/inst/exccode=0, ex=0. Storage array contents need not be reset.
- Occupancy never exceeds DEPTH and never underflows. A bench assertion checks both.

## Timing
- Push-to-issue latency: 1 cycle. A group written at edge N is visible on ibuf_dec_* during cycle N+1.
- Throughput: 1 instruction per cycle out; up to 4 in per cycle.
- Stall holds all ibuf_dec_* outputs stable until the cycle stall drops.
- ibuf_fdp_ready is combinational from registered occupancy, so it is glitch-free within a cycle.
- The first push after flush is allowed in the cycle following flush.

## Configuration
- CPU7_IBUF_BYPASS_EN defined:
  - When occupancy=0, flush=0 and a push occurs, word 0 (or the exception entry) drives ibuf_dec_* combinationally in the same cycle. This gives 0-cycle latency.
  - If that bypassed instruction is consumed (stall=0), only the remaining entries are written.
  - If stall=1, all entries are written normally.
- Undefined: fixed 1-cycle latency. ibuf_dec_* depends only on registered state.

## Test plan
- Reset, then push pc=0x1C000000, count=3, rdata words {A,B,C,D}, no stall. Required: ibuf_dec_valid for 4 consecutive cycles with pc 0x1C000000/04/08/0C and inst A/B/C/D, then valid=0. Latency is 1 cycle, or 0 with CPU7_IBUF_BYPASS_EN.
- Push two 4-word groups back-to-back with stall held high (DEPTH=8). Required: ready drops to 0 once occupancy=8 and occupancy stays at 8. A third push is ignored. After stall is released, 8 in-order issues.
- Push ex=1, exccode=6'h08, count=3. Required: exactly one output entry with ex=1, exccode=0x08, inst=0, pc=group pc.
- Fill to occupancy 5, then assert flush together with a push and no stall. Required: the next cycle has valid=0, ready=1, occupancy=0, and the flushed-cycle group is absent.
- Wrap-around: pushes of count=2 (3 words) interleaved with continuous pops for 20 groups. Required: the PC sequence out is strictly +4 within each group, with no loss or duplication across the pointer wrap.
- Assert reset mid-stream with occupancy=6. Required: the next cycle has valid=0, ready=1 and all output fields 0.
